countdown_timer_ctrl: RTL and testbench
=======================================

Name: countdown_timer_ctrl

Overview:
- Parametrised next-generation countdown timer for the stopwatch/timer top level.
- Single-clock design: an external 1 ms strobe drives the count, not a second clock domain.
- Adds an explicit state machine (IDLE/RUN/PAUSE/EXPIRED), bidirectional time setting, configurable minute range and a blink generator.
- Sits between the button debouncers and the 7-segment display mux.

Parameters:
- MAX_MIN, 59, highest settable minute value; minutes width MIN_W = $clog2(MAX_MIN+1).
- TICKS_PER_SEC, 1000, tick_1ms strobes per second decrement.
- BLINK_HALF, 250, tick_1ms strobes per blink half-period in EXPIRED.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  synchronous active-low reset
- tick_1ms  in  1  single-cycle strobe, one per millisecond
- en  in  1  global enable; gates all counting and blink ticks
- start  in  1  pulse: begin or resume countdown
- stop  in  1  pulse: pause countdown
- clear  in  1  pulse: return to IDLE with 0:00
- inc_min  in  1  pulse: step minutes
- inc_sec  in  1  pulse: step seconds
- down  in  1  set direction: 0 = increment, 1 = decrement
- minutes  out  MIN_W  current minutes
- seconds  out  6  current seconds (0..59)
- running  out  1  high in RUN
- expired  out  1  high in EXPIRED
- blink  out  1  display blink/alarm flag

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, minutes=0, seconds=0, ms_cnt=0, blink=0, running=0, expired=0.
- All outputs are registered. A control pulse sampled at edge N takes effect on outputs after edge N.
- Command priority: clear > start > stop > inc_min/inc_sec. Only the highest-priority asserted command acts in a cycle.
- inc_min and inc_sec together: both fields step in the same cycle.
- clear: from any state goes to IDLE; time=0:00, ms_cnt=0, blink=0.
- Setting is allowed in IDLE, PAUSE and EXPIRED. In EXPIRED, a set pulse moves to IDLE and clears blink. Set pulses are ignored in RUN.
- inc_sec with down=0: 59 -> 0 wraps, no carry. With down=1: 0 -> 59 wraps, no borrow.
- inc_min with down=0: MAX_MIN -> 0 wraps. With down=1: 0 -> MAX_MIN wraps.
- start from IDLE or PAUSE, with time != 0:00, goes to RUN.
  - From IDLE, ms_cnt=0. From PAUSE, ms_cnt is preserved.
  - start with time == 0:00 is ignored; state is unchanged.
- stop in RUN goes to PAUSE. stop in any other state is ignored.
- RUN: when tick_1ms=1 and en=1, ms_cnt increments. At ms_cnt == TICKS_PER_SEC-1, ms_cnt wraps to 0 and time decrements:
  - seconds > 0: seconds-1.
  - seconds == 0: minutes-1, seconds=59.
- If the decremented value is 0:00, state goes to EXPIRED on the same edge.
- en=0 freezes ms_cnt and the blink counter. Commands are still accepted.
- EXPIRED: on entry, blink=1 and blink_cnt=0. Every BLINK_HALF gated ticks, blink toggles. start and stop are ignored (unless the optional feature is enabled).
- blink=0 in every state except EXPIRED.
- running and expired are decoded from the registered state; they are never both 1.

Optional Feature:
- Macro: COUNTDOWN_TIMER_AUTORELOAD_EN.
- Defined:
  - A reload register captures minutes/seconds on every IDLE->RUN transition.
  - On the expiry edge, time reloads and state stays RUN; expired pulses high for one cycle; blink remains 0.
  - start in EXPIRED is unreachable.
- Undefined: no reload register; behaviour exactly as above.

Decomposition:
- Package countdown_timer_pkg:
  - typedef enum logic [1:0] timer_state_t {IDLE, RUN, PAUSE, EXPIRED}.
  - localparam SEC_MAX = 59.
- Sub-module blink_gen, parametrised by BLINK_HALF:
  - Inputs: clk, rst_n, active, tick.
  - Output: blink.
  - Counter and blink clear whenever active=0.

Test Plan:
- Reset then set: rst_n low 2 cycles -> minutes=0, seconds=0, blink=0. Then inc_sec x3 (down=0) -> 0:03; inc_min x1 with down=1 -> MAX_MIN:03 (59:03).
- Countdown with TICKS_PER_SEC=4, BLINK_HALF=2: set 0:02, start, 8 gated ticks -> 0:01 after tick 4; 0:00 and expired=1 after tick 8. Then blink toggles 1,0,1 every 2 ticks.
- Pause/resume: time 1:00, start, 2 ticks, stop, 10 ticks -> still 1:00 with ms_cnt=2. Start, 2 ticks -> 0:59.
- Priority: start, stop and clear asserted in the same cycle while in RUN -> IDLE, 0:00.
- Guards: start at 0:00 -> stays IDLE. inc_sec during RUN -> ignored. en=0 during RUN for 20 ticks -> no change.
- Reset mid-run: time 0:05 RUN, rst_n low 1 cycle -> IDLE, 0:00, running=0. With the autoreload macro: 0:01 run to expiry -> reloads 0:01, one-cycle expired pulse, running stays 1.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared state encoding and field-step helper for the countdown timer slice.
package countdown_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} timer_state_t;

  localparam int SEC_MAX = 59;

  function automatic logic [5:0] sec_step(input logic [5:0] s, input logic dn);
    if (dn) return (s == 6'd0) ? 6'(SEC_MAX) : s - 6'd1;
    else    return (s == 6'(SEC_MAX)) ? 6'd0 : s + 6'd1;
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_blink_gen.sv
// Blink generator: rises on activation, then toggles every BLINK_HALF ticks.
module blink_gen
  import countdown_timer_pkg::*;
#(
  parameter int BLINK_HALF = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic tick,
  output logic blink
);

  localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CNT_W-1:0] cnt;
  logic             armed;

  // First active cycle only arms the output so the entry edge shows blink=1.
  always_ff @(posedge clk) begin
    if (!rst_n || !active) begin
      cnt   <= '0;
      blink <= 1'b0;
      armed <= 1'b0;
    end else if (!armed) begin
      cnt   <= '0;
      blink <= 1'b1;
      armed <= 1'b1;
    end else if (tick) begin
      if (cnt == CNT_W'(BLINK_HALF - 1)) begin
        cnt   <= '0;
        blink <= ~blink;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer FSM (IDLE/RUN/PAUSE/EXPIRED) with bidirectional setting.
// Optional auto-reload on expiry: define COUNTDOWN_TIMER_AUTORELOAD_EN.
module countdown_timer_ctrl
  import countdown_timer_pkg::*;
#(
  parameter  int MAX_MIN       = 59,
  parameter  int TICKS_PER_SEC = 1000,
  parameter  int BLINK_HALF    = 250,
  localparam int MIN_W         = $clog2(MAX_MIN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1ms,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             inc_min,
  input  logic             inc_sec,
  input  logic             down,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic             running,
  output logic             expired,
  output logic             blink
);

  localparam int MS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  timer_state_t     state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic             tick_g, time_zero, last_sec, run_cnt;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [MIN_W-1:0] rl_min;
  logic [5:0]       rl_sec;
  logic             capture, exp_evt;
`endif

  assign tick_g    = tick_1ms & en;
  assign time_zero = (min_q == '0) && (sec_q == 6'd0);
  assign last_sec  = (min_q == '0) && (sec_q == 6'd1);
  // Counting continues in RUN unless clear or an acting stop takes the cycle.
  assign run_cnt   = (state_q == RUN) && !clear && !(stop && !start);

  function automatic logic [MIN_W-1:0] min_step(input logic [MIN_W-1:0] m, input logic dn);
    if (dn) return (m == '0) ? MIN_W'(MAX_MIN) : m - MIN_W'(1);
    else    return (m == MIN_W'(MAX_MIN)) ? '0 : m + MIN_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    ms_d    = ms_q;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    capture = 1'b0;
    exp_evt = 1'b0;
`endif
    if (clear) begin
      state_d = IDLE;
      min_d   = '0;
      sec_d   = 6'd0;
      ms_d    = '0;
    end else if (start) begin
      if ((state_q == IDLE || state_q == PAUSE) && !time_zero) begin
        state_d = RUN;
        if (state_q == IDLE) begin
          ms_d = '0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
          capture = 1'b1;
`endif
        end
      end
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if ((inc_min || inc_sec) && state_q != RUN) begin
      if (inc_min) min_d = min_step(min_q, down);
      if (inc_sec) sec_d = sec_step(sec_q, down);
      if (state_q == EXPIRED) state_d = IDLE;
    end

    if (run_cnt && tick_g) begin
      if (ms_q == MS_W'(TICKS_PER_SEC - 1)) begin
        ms_d = '0;
        if (sec_q != 6'd0) begin
          sec_d = sec_q - 6'd1;
        end else begin
          min_d = min_q - MIN_W'(1);
          sec_d = 6'(SEC_MAX);
        end
        if (last_sec) begin
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
          min_d   = rl_min;
          sec_d   = rl_sec;
          exp_evt = 1'b1;
`else
          state_d = EXPIRED;
`endif
        end
      end else begin
        ms_d = ms_q + MS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      min_q   <= '0;
      sec_q   <= 6'd0;
      ms_q    <= '0;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      ms_q    <= ms_d;
      running <= (state_d == RUN);
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      expired <= exp_evt;
`else
      expired <= (state_d == EXPIRED);
`endif
    end
  end

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  always_ff @(posedge clk) begin
    if (capture) begin
      rl_min <= min_d;
      rl_sec <= sec_d;
    end
  end
`endif

  assign minutes = min_q;
  assign seconds = sec_q;

  blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (state_d == EXPIRED),
    .tick   (tick_g),
    .blink  (blink)
  );

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with TICKS_PER_SEC=4, BLINK_HALF=2.
module tb_countdown_timer_ctrl;

  localparam int MAX_MIN = 59;
  localparam int MIN_W   = $clog2(MAX_MIN + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             tick_1ms = 1'b0, en = 1'b1;
  logic             start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic             inc_min = 1'b0, inc_sec = 1'b0, down = 1'b0;
  logic [MIN_W-1:0] minutes;
  logic [5:0]       seconds;
  logic             running, expired, blink;

  int passed = 0;
  int total  = 0;

  countdown_timer_ctrl #(.MAX_MIN(MAX_MIN), .TICKS_PER_SEC(4), .BLINK_HALF(2)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1ms(tick_1ms), .en(en),
    .start(start), .stop(stop), .clear(clear),
    .inc_min(inc_min), .inc_sec(inc_sec), .down(down),
    .minutes(minutes), .seconds(seconds),
    .running(running), .expired(expired), .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    string cmd;
    int    e_min;
    int    e_sec;
    bit    e_run;
    bit    e_exp;
    bit    e_blink;
  } vec_t;

  vec_t vecs[$];

  // Command letters: R reset, T tick, x en=0, S start, P stop, C clear,
  // m inc_min, s inc_sec, d down; "-" idles for a cycle.
  task automatic cyc(input string cmd);
    for (int i = 0; i < cmd.len(); i++) begin
      case (cmd[i])
        "R": rst_n    = 1'b0;
        "T": tick_1ms = 1'b1;
        "x": en       = 1'b0;
        "S": start    = 1'b1;
        "P": stop     = 1'b1;
        "C": clear    = 1'b1;
        "m": inc_min  = 1'b1;
        "s": inc_sec  = 1'b1;
        "d": down     = 1'b1;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; tick_1ms = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0;
    clear = 1'b0; inc_min = 1'b0; inc_sec = 1'b0; down = 1'b0;
  endtask

  task automatic chk(input string name, input int em, input int es,
                     input bit er, input bit ee, input bit eb);
    total++;
    if (minutes !== MIN_W'(em) || seconds !== 6'(es) || running !== er ||
        expired !== ee || blink !== eb)
      $display("FAIL %s: got %0d:%0d run=%b exp=%b blink=%b, expected %0d:%0d run=%b exp=%b blink=%b",
               name, minutes, seconds, running, expired, blink, em, es, er, ee, eb);
    else
      passed++;
  endtask

  task automatic add(input string cmd, input int em, input int es,
                     input bit er, input bit ee, input bit eb);
    vec_t v;
    v.cmd = cmd; v.e_min = em; v.e_sec = es; v.e_run = er; v.e_exp = ee; v.e_blink = eb;
    vecs.push_back(v);
  endtask

  initial begin
    add("R",   0, 0, 0, 0, 0);
    add("R",   0, 0, 0, 0, 0);
    add("s",   0, 1, 0, 0, 0);
    add("s",   0, 2, 0, 0, 0);
    add("s",   0, 3, 0, 0, 0);
    add("md", 59, 3, 0, 0, 0);
    add("sd", 59, 2, 0, 0, 0);
    add("C",   0, 0, 0, 0, 0);
    add("sd",  0, 59, 0, 0, 0);
    add("s",   0, 0, 0, 0, 0);
    add("md", 59, 0, 0, 0, 0);
    add("m",   0, 0, 0, 0, 0);
    add("ms", 1, 1, 0, 0, 0);
    add("C",   0, 0, 0, 0, 0);
    add("S",   0, 0, 0, 0, 0);
    add("s",   0, 1, 0, 0, 0);
    add("s",   0, 2, 0, 0, 0);
    add("S",   0, 2, 1, 0, 0);
    add("T",   0, 2, 1, 0, 0);
    add("T",   0, 2, 1, 0, 0);
    add("T",   0, 2, 1, 0, 0);
    add("T",   0, 1, 1, 0, 0);
    add("s",   0, 1, 1, 0, 0);
    add("Tx",  0, 1, 1, 0, 0);
    add("Tx",  0, 1, 1, 0, 0);
`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
    add("T",   0, 1, 1, 0, 0);
    add("T",   0, 1, 1, 0, 0);
    add("T",   0, 1, 1, 0, 0);
    add("T",   0, 0, 0, 1, 1);
    add("T",   0, 0, 0, 1, 1);
    add("T",   0, 0, 0, 1, 0);
    add("T",   0, 0, 0, 1, 0);
    add("T",   0, 0, 0, 1, 1);
    add("S",   0, 0, 0, 1, 1);
    add("P",   0, 0, 0, 1, 1);
    add("s",   0, 1, 0, 0, 0);
`endif
    add("C",   0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].cmd);
      chk($sformatf("vec%0d_%s", i, vecs[i].cmd), vecs[i].e_min, vecs[i].e_sec,
          vecs[i].e_run, vecs[i].e_exp, vecs[i].e_blink);
    end

    // Pause keeps the sub-second count: 2 ticks before stop + 2 after resume = 1 s.
    cyc("m");
    cyc("S");
    cyc("T"); cyc("T");
    cyc("P");
    chk("pause_enter", 1, 0, 0, 0, 0);
    repeat (10) cyc("T");
    chk("pause_hold", 1, 0, 0, 0, 0);
    cyc("S");
    chk("resume", 1, 0, 1, 0, 0);
    cyc("T");
    chk("resume_tick1", 1, 0, 1, 0, 0);
    cyc("T");
    chk("resume_tick2", 0, 59, 1, 0, 0);

    cyc("SPC");
    chk("priority_clear", 0, 0, 0, 0, 0);
    cyc("P");
    chk("stop_in_idle", 0, 0, 0, 0, 0);

    repeat (5) cyc("s");
    cyc("S");
    repeat (20) cyc("Tx");
    chk("en_low_freeze", 0, 5, 1, 0, 0);
    cyc("R");
    chk("reset_mid_run", 0, 0, 0, 0, 0);

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    cyc("s");
    cyc("S");
    repeat (3) cyc("T");
    chk("ar_before", 0, 1, 1, 0, 0);
    cyc("T");
    chk("ar_reload", 0, 1, 1, 1, 0);
    cyc("-");
    chk("ar_pulse_end", 0, 1, 1, 0, 0);
    cyc("C");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
